hazard_controller: RTL and testbench

- Sequences stalls and flushes for the 5-stage MIPS pipeline.
- Drives PC hold, IF/ID hold, ID/EX bubble insertion and IF flush.
- Selects ID-stage forwarding for the beq/bne comparator.
- Holds a small FSM and counter so that multi-cycle stalls (branch depending on a load) run to completion deterministically.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/hazard_match.sv | 18 +
 rtl/hazard_controller.sv | 170 +++++++++++++++++
 tb/tb_hazard_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the hazard controller: register width, FSM encoding
// and per-rule stall lengths.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    StRun  = 1'b0,
    StWait = 1'b1
  } hz_state_e;

  localparam int unsigned LOAD_USE_STALL    = 1;
  localparam int unsigned BR_ALU_EX_STALL   = 1;
  localparam int unsigned BR_LOAD_EX_STALL  = 2;
  localparam int unsigned BR_LOAD_MEM_STALL = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one destination specifier against the ID-stage rs/rt; register 0 never matches.
module hazard_match
  import pipeline_pkg::*;
#(
  parameter int unsigned Width = REG_ADDR_W
) (
  input  logic [Width-1:0] rd_i,
  input  logic [Width-1:0] rs_i,
  input  logic [Width-1:0] rt_i,
  input  logic             uses_rt_i,
  output logic             match_o
);

  always_comb begin
    match_o = (rd_i != '0) && ((rd_i == rs_i) || (uses_rt_i && (rd_i == rt_i)));
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer and ID-stage forwarding select for the 5-stage MIPS pipeline.
// Optional saturating perf counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int unsigned MAX_STALL  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_is_branch,
  input  logic                  id_is_jump,
  input  logic                  id_branch_taken,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  id_ex_flush,
  output logic                  if_flush,
  output logic                  fwd_a_id,
  output logic                  fwd_b_id,
  output logic                  stalling
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_cycles
`endif
);

  localparam int unsigned CntW = $clog2(MAX_STALL + 1);

  logic ex_hit, mem_hit;

  hazard_match #(
    .Width(REG_ADDR_W)
  ) u_match_ex (
    .rd_i     (ex_rd),
    .rs_i     (id_rs),
    .rt_i     (id_rt),
    .uses_rt_i(id_uses_rt),
    .match_o  (ex_hit)
  );

  hazard_match #(
    .Width(REG_ADDR_W)
  ) u_match_mem (
    .rd_i     (mem_rd),
    .rs_i     (id_rs),
    .rt_i     (id_rt),
    .uses_rt_i(id_uses_rt),
    .match_o  (mem_hit)
  );

  int unsigned     need_raw;
  logic [CntW-1:0] need;

  always_comb begin
    need_raw = 0;
    if (ex_mem_read && ex_hit) begin
      need_raw = max_u(need_raw, LOAD_USE_STALL);
    end
    if (id_is_branch && ex_reg_write && !ex_mem_read && ex_hit) begin
      need_raw = max_u(need_raw, BR_ALU_EX_STALL);
    end
    if (id_is_branch && ex_mem_read && ex_hit) begin
      need_raw = max_u(need_raw, BR_LOAD_EX_STALL);
    end
    if (id_is_branch && mem_mem_read && mem_hit) begin
      need_raw = max_u(need_raw, BR_LOAD_MEM_STALL);
    end
    need = CntW'((need_raw > MAX_STALL) ? MAX_STALL : need_raw);
  end

  hz_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stall;

  // cnt holds the stall cycles still owed after the current WAIT cycle plus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (need != '0) begin
          stall = 1'b1;
          if (need > CntW'(1)) begin
            cnt_d   = need - CntW'(1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StRun;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    id_ex_flush = 1'b0;
    if_flush    = 1'b0;
    fwd_a_id    = 1'b0;
    fwd_b_id    = 1'b0;
    stalling    = 1'b0;
    if (!reset) begin
      pc_hold     = stall;
      if_id_hold  = stall;
      id_ex_flush = stall;
      stalling    = stall;
      // A pending redirect waits until the stall drains so it is squashed exactly once.
      if_flush    = !stall && (id_is_jump || (id_is_branch && id_branch_taken));
      fwd_a_id    = mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == id_rs);
      fwd_b_id    = mem_reg_write && !mem_mem_read && (mem_rd != '0) && id_uses_rt &&
                    (mem_rd == id_rt);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (stalling && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (if_flush && (flush_cycles_q != 32'hFFFF_FFFF)) begin
      flush_cycles_d = flush_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a pending-stall-count model.
module tb_hazard_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rt, id_is_branch, id_is_jump, id_branch_taken;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
  logic       pc_hold, if_id_hold, id_ex_flush, if_flush, fwd_a_id, fwd_b_id, stalling;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
  longint      m_stall_cnt = 0;
  longint      m_flush_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int pending = 0;  // stall cycles still owed after the current one

  always #5 clock = ~clock;

  hazard_controller dut (
    .clock          (clock),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .id_is_branch   (id_is_branch),
    .id_is_jump     (id_is_jump),
    .id_branch_taken(id_branch_taken),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_rd         (mem_rd),
    .pc_hold        (pc_hold),
    .if_id_hold     (if_id_hold),
    .id_ex_flush    (id_ex_flush),
    .if_flush       (if_flush),
    .fwd_a_id       (fwd_a_id),
    .fwd_b_id       (fwd_b_id),
    .stalling       (stalling)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
`endif
  );

  function automatic logic [6:0] dut_vec();
    return {pc_hold, if_id_hold, id_ex_flush, if_flush, fwd_a_id, fwd_b_id, stalling};
  endfunction

  function automatic bit hit(input logic [4:0] r);
    return (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt));
  endfunction

  // Reference: evaluates this cycle's outputs, compares, then advances the owed-stall count.
  task automatic check_model();
    int n;
    bit st, fl, fa, fb;
    logic [6:0] exp;
    n = 0;
    if (ex_mem_read && hit(ex_rd)) n = (n > 1) ? n : 1;
    if (id_is_branch && ex_reg_write && !ex_mem_read && hit(ex_rd)) n = (n > 1) ? n : 1;
    if (id_is_branch && ex_mem_read && hit(ex_rd)) n = 2;
    if (id_is_branch && mem_mem_read && hit(mem_rd)) n = (n > 1) ? n : 1;
    st = (pending > 0) || (n > 0);
    fl = !st && (id_is_jump || (id_is_branch && id_branch_taken));
    fa = mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == id_rs;
    fb = mem_reg_write && !mem_mem_read && mem_rd != 0 && id_uses_rt && mem_rd == id_rt;
    exp = reset ? 7'b0 : {st, st, st, fl, fa, fb, st};
    checks++;
    if (dut_vec() !== exp) begin
      errors++;
      $display("FAIL model t=%0t got=%b want=%b", $time, dut_vec(), exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'(m_stall_cnt) || flush_cycles !== 32'(m_flush_cnt)) begin
      errors++;
      $display("FAIL perf got=%0d/%0d want=%0d/%0d", stall_cycles, flush_cycles,
               m_stall_cnt, m_flush_cnt);
    end
    if (reset) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      m_stall_cnt += st;
      m_flush_cnt += fl;
    end
`endif
    if (reset) pending = 0;
    else if (pending > 0) pending = pending - 1;
    else if (n > 0) pending = n - 1;
  endtask

  task automatic set_in(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urt, input bit br, input bit jmp, input bit tk,
                        input bit exw, input bit exr, input logic [4:0] exrd,
                        input bit mw, input bit mr, input logic [4:0] mrd);
    @(posedge clock);
    #1;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_is_branch = br;
    id_is_jump = jmp; id_branch_taken = tk; ex_reg_write = exw; ex_mem_read = exr;
    ex_rd = exrd; mem_reg_write = mw; mem_mem_read = mr; mem_rd = mrd;
    @(negedge clock);
    check_model();
  endtask

  // Literal expectation; vector order {pc_hold,if_id_hold,id_ex_flush,if_flush,fa,fb,stall}.
  task automatic expect_out(input string name, input logic [6:0] exp);
    checks++;
    if (dut_vec() !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, dut_vec(), exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_uses_rt = 0; id_is_branch = 0; id_is_jump = 0; id_branch_taken = 0;
    ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0; mem_mem_read = 0;

    set_in(1, 8, 0, 0, 0, 1, 0, 0, 1, 8, 0, 0, 0);
    expect_out("reset_forces_zero", 7'b0000000);

    set_in(0, 8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0);
    expect_out("load_use_stall", 7'b1110001);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("load_use_done", 7'b0000000);

    set_in(0, 1, 9, 1, 1, 0, 1, 1, 1, 9, 0, 0, 0);
    expect_out("br_load_ex_c1", 7'b1110001);
    set_in(0, 1, 9, 1, 1, 0, 1, 1, 1, 9, 0, 0, 0);
    expect_out("br_load_ex_c2", 7'b1110001);
    set_in(0, 1, 9, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    expect_out("br_load_ex_resolve", 7'b0001000);

    set_in(0, 5, 7, 1, 1, 0, 1, 0, 0, 0, 1, 0, 5);
    expect_out("fwd_a_taken", 7'b0001100);
    set_in(0, 3, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 6);
    expect_out("fwd_b", 7'b0000010);
    set_in(0, 3, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6);
    expect_out("fwd_b_no_rt", 7'b0000000);
    set_in(0, 4, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 4);
    expect_out("br_load_mem", 7'b1110001);

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    expect_out("reg0_no_hazard", 7'b0000000);

    set_in(0, 8, 0, 0, 0, 1, 0, 1, 1, 8, 0, 0, 0);
    expect_out("jump_loaduse_stall", 7'b1110001);
    set_in(0, 8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("jump_flush_after", 7'b0001000);

    set_in(0, 1, 9, 1, 1, 0, 1, 1, 1, 9, 0, 0, 0);
    expect_out("wait_entry", 7'b1110001);
    set_in(1, 1, 9, 1, 1, 0, 1, 1, 1, 9, 0, 0, 0);
    expect_out("reset_in_wait", 7'b0000000);
    set_in(0, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    expect_out("run_after_reset", 7'b0001000);

    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 49) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
